// File: rtl/cnt_pkg.sv
// Package: cnt_pkg
// Shared definitions for the modulo counter family.
//   cnt_width(modulo) : register width needed to hold 0..modulo-1, never below 1.
// Assertion macros (simulation only, used inside the counter modules):
//   CNT_ASSERT_IN_RANGE(label, clk, sig, lim)  : sig < lim on every rising edge.
//   CNT_ASSERT_HOLD(label, clk, rst, ce, sig)  : sig unchanged after an edge with rst=0, ce=0.
//   CNT_ASSERT_RESET(label, clk, rst, sig)     : sig == 0 one edge after rst=1.

`define CNT_ASSERT_IN_RANGE(label, clk, sig, lim) \
  label: assert property (@(posedge clk) (32'(sig) < (lim))) \
    else $error("counter value out of range");

`define CNT_ASSERT_HOLD(label, clk, rst, ce, sig) \
  label: assert property (@(posedge clk) (!(rst) && !(ce)) |=> $stable(sig)) \
    else $error("counter changed while not enabled");

`define CNT_ASSERT_RESET(label, clk, rst, sig) \
  label: assert property (@(posedge clk) (rst) |=> ((sig) == '0)) \
    else $error("counter not zero after reset");

package cnt_pkg;

  // $clog2 returns 0 for modulo <= 1; clamp so the register is at least one bit.
  function automatic int unsigned cnt_width(input int unsigned modulo);
    int unsigned w;
    w = $clog2(modulo);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/cnt_mod_n.sv
// Module: cnt_mod_n
// Synchronous up-counter modulo MODULO (0,1,...,MODULO-1,0,...), advancing
// only while ce is high. Provides terminal-count and wrap flags so counters
// can be cascaded (wrap of one stage feeds ce of the next).
// Parameters:
//   MODULO : number of states, must be >= 2
//   WIDTH  : derived register width, not overridable
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, wins over ce
//   ce   : count enable, active-high
//   out  : registered count, 0..MODULO-1
//   tc   : high while out == MODULO-1 (combinational)
//   wrap : ce & tc, high in the cycle whose next edge returns out to 0

module cnt_mod_n
  import cnt_pkg::*;
#(
  parameter  int unsigned MODULO = 7,
  localparam int unsigned WIDTH  = cnt_width(MODULO)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap
);

  if (MODULO < 2) begin : g_bad_modulo
    $error("cnt_mod_n: MODULO must be at least 2");
  end

  // Terminal value compared explicitly so non-power-of-two moduli never
  // reach the unused codes; power-of-two moduli use the same compare.
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULO - 1);

  // Power-up value keeps simulation defined before the first reset.
  logic [WIDTH-1:0] r_out = '0;
  logic             w_at_last;
  logic [WIDTH-1:0] w_next;

  assign w_at_last = (r_out == LAST);
  // out+1 cannot overflow WIDTH bits because out < MODULO-1 when it is taken.
  assign w_next    = w_at_last ? '0 : r_out + WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
    end else if (ce) begin
      r_out <= w_next;
    end
  end

  assign out  = r_out;
  assign tc   = w_at_last;
  assign wrap = ce & w_at_last;

`ifndef SYNTHESIS
  `CNT_ASSERT_IN_RANGE(a_range, clk, r_out, MODULO)
  `CNT_ASSERT_HOLD(a_hold, clk, rst, ce, r_out)
  `CNT_ASSERT_RESET(a_reset, clk, rst, r_out)
`endif

endmodule

// File: tb/tb_cnt_mod_n.sv
module tb_cnt_mod_n;

  logic       clk;
  logic       rst;
  logic       ce;
  logic [2:0] o7;
  logic [2:0] o8;
  logic [3:0] o9;
  logic [0:0] o2;
  logic       tc7, tc8, tc9, tc2;
  logic       wr7, wr8, wr9, wr2;

  int errors = 0;
  int checks = 0;

  // Reference: number of enabled edges since the last reset; each counter
  // is expected to equal this value modulo its own MODULO.
  int unsigned n_ce = 0;

  typedef struct {
    int unsigned e7;
    int unsigned e8;
    int unsigned e9;
    int unsigned e2;
  } exp_t;

  exp_t sb[$];

  cnt_mod_n #(.MODULO(7)) u_m7 (.clk(clk), .rst(rst), .ce(ce), .out(o7), .tc(tc7), .wrap(wr7));
  cnt_mod_n #(.MODULO(8)) u_m8 (.clk(clk), .rst(rst), .ce(ce), .out(o8), .tc(tc8), .wrap(wr8));
  cnt_mod_n #(.MODULO(9)) u_m9 (.clk(clk), .rst(rst), .ce(ce), .out(o9), .tc(tc9), .wrap(wr9));
  cnt_mod_n #(.MODULO(2)) u_m2 (.clk(clk), .rst(rst), .ce(ce), .out(o2), .tc(tc2), .wrap(wr2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Drive one cycle of stimulus, check the combinational flags against the
  // reference before the edge, push the post-edge expectation, then pop and
  // compare it once the DUTs have registered the edge.
  task automatic step(input string tag, input logic r, input logic c);
    exp_t        e;
    exp_t        got;
    int unsigned x7, x8, x9, x2;
    logic        etc7, etc8, etc9, etc2;
    rst = r;
    ce  = c;
    #1;
    x7 = n_ce % 7;  x8 = n_ce % 8;  x9 = n_ce % 9;  x2 = n_ce % 2;
    etc7 = (x7 == 6); etc8 = (x8 == 7); etc9 = (x9 == 8); etc2 = (x2 == 1);
    checks++; if (tc7 !== etc7) begin errors++; $display("FAIL %s tc7: got %b want %b", tag, tc7, etc7); end
    checks++; if (tc8 !== etc8) begin errors++; $display("FAIL %s tc8: got %b want %b", tag, tc8, etc8); end
    checks++; if (tc9 !== etc9) begin errors++; $display("FAIL %s tc9: got %b want %b", tag, tc9, etc9); end
    checks++; if (tc2 !== etc2) begin errors++; $display("FAIL %s tc2: got %b want %b", tag, tc2, etc2); end
    checks++; if (wr7 !== (c & etc7)) begin errors++; $display("FAIL %s wrap7: got %b want %b", tag, wr7, c & etc7); end
    checks++; if (wr8 !== (c & etc8)) begin errors++; $display("FAIL %s wrap8: got %b want %b", tag, wr8, c & etc8); end
    checks++; if (wr9 !== (c & etc9)) begin errors++; $display("FAIL %s wrap9: got %b want %b", tag, wr9, c & etc9); end
    checks++; if (wr2 !== (c & etc2)) begin errors++; $display("FAIL %s wrap2: got %b want %b", tag, wr2, c & etc2); end
    if (r) n_ce = 0;
    else if (c) n_ce++;
    e.e7 = n_ce % 7; e.e8 = n_ce % 8; e.e9 = n_ce % 9; e.e2 = n_ce % 2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue want 1 entry", tag);
    end else begin
      got = sb.pop_front();
      if (o7 !== 3'(got.e7)) begin errors++; $display("FAIL %s out7: got %0d want %0d", tag, o7, got.e7); end
      checks++; if (o8 !== 3'(got.e8)) begin errors++; $display("FAIL %s out8: got %0d want %0d", tag, o8, got.e8); end
      checks++; if (o9 !== 4'(got.e9)) begin errors++; $display("FAIL %s out9: got %0d want %0d", tag, o9, got.e9); end
      checks++; if (o2 !== 1'(got.e2)) begin errors++; $display("FAIL %s out2: got %0d want %0d", tag, o2, got.e2); end
    end
  endtask

  task automatic test_reset();
    // Power-up value before any edge.
    #1;
    checks++;
    if (o7 !== 3'd0 || o9 !== 4'd0) begin
      errors++;
      $display("FAIL powerup: got o7=%0d o9=%0d want 0 0", o7, o9);
    end
    step("reset", 1'b1, 1'b0);
    step("reset", 1'b1, 1'b0);
    checks++;
    if (o7 !== 3'd0 || tc7 !== 1'b0 || wr7 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got out=%0d tc=%b wrap=%b want 0 0 0", o7, tc7, wr7);
    end
  endtask

  task automatic test_count();
    for (int i = 0; i < 16; i++) step("count", 1'b0, 1'b1);
    // 16 enabled edges: 16 mod 7 = 2.
    checks++;
    if (o7 !== 3'd2) begin errors++; $display("FAIL count_end: got %0d want 2", o7); end
  endtask

  task automatic test_hold();
    step("hold_rst", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("hold_up", 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step("hold", 1'b0, 1'b0);
      checks++;
      if (o7 !== 3'd3) begin errors++; $display("FAIL hold_at3: got %0d want 3", o7); end
    end
    step("hold_resume", 1'b0, 1'b1);
    checks++;
    if (o7 !== 3'd4) begin errors++; $display("FAIL hold_resume: got %0d want 4", o7); end
    step("hold_up", 1'b0, 1'b1);
    step("hold_up", 1'b0, 1'b1);
    // Sitting at 6 with ce low: tc high, wrap must stay low.
    for (int i = 0; i < 3; i++) step("hold_at6", 1'b0, 1'b0);
    checks++;
    if (o7 !== 3'd6 || tc7 !== 1'b1 || wr7 !== 1'b0) begin
      errors++;
      $display("FAIL hold_at6: got out=%0d tc=%b wrap=%b want 6 1 0", o7, tc7, wr7);
    end
  endtask

  task automatic test_reset_mid();
    step("mid_rst", 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("mid_up", 1'b0, 1'b1);
    checks++;
    if (o7 !== 3'd5) begin errors++; $display("FAIL mid_at5: got %0d want 5", o7); end
    for (int i = 0; i < 4; i++) begin
      step("mid_rst_ce", 1'b1, 1'b1);
      checks++;
      if (o7 !== 3'd0) begin errors++; $display("FAIL mid_rst_ce: got %0d want 0", o7); end
    end
  endtask

  task automatic test_widths();
    step("width_rst", 1'b1, 1'b0);
    // 20 edges cover full cycles of 2, 7, 8 and 9 including each wrap.
    for (int i = 0; i < 20; i++) begin
      step("width", 1'b0, 1'b1);
      checks++;
      if (o9 > 4'd8) begin errors++; $display("FAIL width9_range: got %0d want <=8", o9); end
    end
  endtask

  task automatic test_random();
    step("rand_rst", 1'b1, 1'b0);
    for (int i = 0; i < 1000; i++) step("random", 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic test_back_to_back();
    // Reset pulses interleaved with counting.
    for (int k = 0; k < 4; k++) begin
      step("b2b_rst", 1'b1, 1'($urandom_range(0, 1)));
      for (int i = 0; i < k + 6; i++) step("b2b", 1'b0, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b0;
    ce  = 1'b0;
    test_reset();
    test_count();
    test_hold();
    test_reset_mid();
    test_widths();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
